// File: rtl/prime_guess_engine_if.sv
// Game-side signal bundle of the prime guessing engine: player/timer inputs and game status outputs.
interface prime_guess_engine_if;
  logic       enable;
  logic       btn_pulse;
  logic [3:0] data_inp;
  logic [1:0] gameLevel;
  logic       timeout;
  logic       signalLess;
  logic       signalGreater;
  logic       userWon;
  logic       userLost;
  logic       decrement;
  logic [3:0] attemptsLeft;
  logic [6:0] secretPrime;

  modport slave (
    input  enable, btn_pulse, data_inp, gameLevel, timeout,
    output signalLess, signalGreater, userWon, userLost, decrement, attemptsLeft, secretPrime
  );

  modport master (
    output enable, btn_pulse, data_inp, gameLevel, timeout,
    input  signalLess, signalGreater, userWon, userLost, decrement, attemptsLeft, secretPrime
  );
endinterface

// File: rtl/prime_guess_engine.sv
// Guess-the-prime game: LFSR picks one of the primes 2..97, the player enters two BCD digits
// per guess and gets less/greater hints until a win, running out of attempts, or a timeout.
module prime_guess_engine #(
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic                 clk,
  input  logic                 reset,
  prime_guess_engine_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, PICK, WAIT_TENS, WAIT_UNITS, COMPARE, WON, LOST
  } state_t;

  state_t     state, state_next;
  logic [7:0] lfsr;
  logic [3:0] tens, units;
  logic [4:0] raw_idx, idx;
  logic [6:0] guess;
  logic       digit_ok, guess_hit, guess_low;
  logic [3:0] attempts_dec;

  logic       less_q, greater_q, won_q, lost_q, dec_q;
  logic [3:0] attempts_q;
  logic [6:0] secret_q;

  // NOTE: the prime table is a constant lookup, so there is no storage to reset.
  function automatic logic [6:0] prime_at(input logic [4:0] i);
    case (i)
      5'd0:  prime_at = 7'd2;   5'd1:  prime_at = 7'd3;   5'd2:  prime_at = 7'd5;
      5'd3:  prime_at = 7'd7;   5'd4:  prime_at = 7'd11;  5'd5:  prime_at = 7'd13;
      5'd6:  prime_at = 7'd17;  5'd7:  prime_at = 7'd19;  5'd8:  prime_at = 7'd23;
      5'd9:  prime_at = 7'd29;  5'd10: prime_at = 7'd31;  5'd11: prime_at = 7'd37;
      5'd12: prime_at = 7'd41;  5'd13: prime_at = 7'd43;  5'd14: prime_at = 7'd47;
      5'd15: prime_at = 7'd53;  5'd16: prime_at = 7'd59;  5'd17: prime_at = 7'd61;
      5'd18: prime_at = 7'd67;  5'd19: prime_at = 7'd71;  5'd20: prime_at = 7'd73;
      5'd21: prime_at = 7'd79;  5'd22: prime_at = 7'd83;  5'd23: prime_at = 7'd89;
      5'd24: prime_at = 7'd97;
      default: prime_at = 7'd0;
    endcase
  endfunction

  function automatic logic [3:0] attempts_for(input logic [1:0] level);
    case (level)
      2'd0:    attempts_for = 4'd8;
      2'd1:    attempts_for = 4'd6;
      2'd2:    attempts_for = 4'd4;
      default: attempts_for = 4'd3;
    endcase
  endfunction

  assign raw_idx      = lfsr[4:0];
  assign idx          = (raw_idx < 5'd25) ? raw_idx : raw_idx - 5'd25;
  assign digit_ok     = bus.data_inp <= 4'd9;
  assign guess        = {3'b000, tens} * 7'd10 + {3'b000, units};
  assign guess_hit    = guess == secret_q;
  assign guess_low    = guess < secret_q;
  assign attempts_dec = (attempts_q == 4'd0) ? 4'd0 : attempts_q - 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:       if (bus.enable) state_next = PICK;
      PICK:       state_next = WAIT_TENS;
      WAIT_TENS:  if (bus.timeout) state_next = LOST;
                  else if (bus.btn_pulse && digit_ok) state_next = WAIT_UNITS;
      WAIT_UNITS: if (bus.timeout) state_next = LOST;
                  else if (bus.btn_pulse && digit_ok) state_next = COMPARE;
      COMPARE:    if (bus.timeout)                 state_next = LOST;
                  else if (guess_hit)              state_next = WON;
                  else if (attempts_dec == 4'd0)   state_next = LOST;
                  else                             state_next = WAIT_TENS;
      WON, LOST:  state_next = state;
      default:    state_next = IDLE;
    endcase
    if (!bus.enable) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr       <= LFSR_SEED;
      tens       <= '0;
      units      <= '0;
      less_q     <= 1'b0;
      greater_q  <= 1'b0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
      dec_q      <= 1'b0;
      attempts_q <= '0;
      secret_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      lfsr  <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      dec_q <= 1'b0;
      if (!bus.enable) begin
        less_q     <= 1'b0;
        greater_q  <= 1'b0;
        won_q      <= 1'b0;
        lost_q     <= 1'b0;
        attempts_q <= '0;
      end else begin
        case (state)
          IDLE: begin
            less_q    <= 1'b0;
            greater_q <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
          end
          PICK: begin
            secret_q   <= prime_at(idx);
            attempts_q <= attempts_for(bus.gameLevel);
          end
          WAIT_TENS:
            if (bus.timeout) lost_q <= 1'b1;
            else if (bus.btn_pulse && digit_ok) tens <= bus.data_inp;
          WAIT_UNITS:
            if (bus.timeout) lost_q <= 1'b1;
            else if (bus.btn_pulse && digit_ok) units <= bus.data_inp;
          COMPARE:
            if (bus.timeout) begin
              lost_q <= 1'b1;
            end else if (guess_hit) begin
              won_q     <= 1'b1;
              less_q    <= 1'b0;
              greater_q <= 1'b0;
            end else begin
              less_q     <= guess_low;
              greater_q  <= ~guess_low;
              attempts_q <= attempts_dec;
              dec_q      <= 1'b1;
              if (attempts_dec == 4'd0) lost_q <= 1'b1;
            end
          default: ;
        endcase
      end
    end
  end

  assign bus.signalLess    = less_q;
  assign bus.signalGreater = greater_q;
  assign bus.userWon       = won_q;
  assign bus.userLost      = lost_q;
  assign bus.decrement     = dec_q;
  assign bus.attemptsLeft  = attempts_q;
  assign bus.secretPrime   = secret_q;

endmodule

// File: tb/tb_prime_guess_engine.sv
// Bench for prime_guess_engine: table-driven games, hand-written corner sequences and
// random games checked against a transaction-level model of the game rules.
module tb_prime_guess_engine;
  localparam logic [7:0] SEED = 8'h01;

  logic clk = 1'b0;
  logic reset;
  prime_guess_engine_if bus();

  prime_guess_engine #(.LFSR_SEED(SEED)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int         primes[25];
  int         level_attempts[4] = '{8, 6, 4, 3};
  logic [7:0] m_lfsr;

  // expected game status
  int e_less, e_greater, e_won, e_lost, e_att, e_secret, e_dec;

  typedef struct {
    bit new_game;
    int level;
    int delta;
    int less;
    int greater;
    int won;
    int lost;
    int att;
    int dec;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic int secret_of(input logic [7:0] l);
    int v;
    v = int'(l[4:0]);
    if (v >= 25) v -= 25;
    return primes[v];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) m_lfsr = lfsr_next(m_lfsr);
    @(negedge clk);
  endtask

  task automatic check_all(input string name);
    check({name, " less"},    int'(bus.signalLess),    e_less);
    check({name, " greater"}, int'(bus.signalGreater), e_greater);
    check({name, " won"},     int'(bus.userWon),       e_won);
    check({name, " lost"},    int'(bus.userLost),      e_lost);
    check({name, " attempts"},int'(bus.attemptsLeft),  e_att);
    check({name, " secret"},  int'(bus.secretPrime),   e_secret);
  endtask

  task automatic clear_model();
    e_less = 0; e_greater = 0; e_won = 0; e_lost = 0; e_att = 0; e_dec = 0;
  endtask

  task automatic start_game(input int level);
    int sec;
    bus.gameLevel = 2'(level);
    bus.enable    = 1'b1;
    tick();
    sec = secret_of(m_lfsr);
    tick();
    clear_model();
    e_secret = sec;
    e_att    = level_attempts[level];
    check_all($sformatf("pick L%0d", level));
  endtask

  task automatic end_game();
    bus.enable = 1'b0;
    tick();
    clear_model();
    check_all("disable");
  endtask

  task automatic enter_digit(input int d);
    bus.btn_pulse = 1'b1;
    bus.data_inp  = 4'(d);
    tick();
    bus.btn_pulse = 1'b0;
    bus.data_inp  = 4'd0;
  endtask

  function automatic void apply_guess(input int g);
    if (g == e_secret) begin
      e_won = 1; e_less = 0; e_greater = 0; e_dec = 0;
    end else begin
      e_less    = (g < e_secret) ? 1 : 0;
      e_greater = (g > e_secret) ? 1 : 0;
      e_att     = (e_att > 0) ? e_att - 1 : 0;
      e_dec     = 1;
      if (e_att == 0) e_lost = 1;
    end
  endfunction

  task automatic run_guess(input int g, input string name);
    enter_digit(g / 10);
    enter_digit(g % 10);
    tick();
    apply_guess(g);
    check_all(name);
    check({name, " dec"}, int'(bus.decrement), e_dec);
    tick();
    e_dec = 0;
    check({name, " dec_end"}, int'(bus.decrement), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int n;
    int g;
    int r;
    bit is_p;

    n = 0;
    for (int v = 2; n < 25; v++) begin
      is_p = 1'b1;
      for (int d = 2; d * d <= v; d++) if (v % d == 0) is_p = 1'b0;
      if (is_p) begin
        primes[n] = v;
        n++;
      end
    end

    vecs[0] = '{1, 0, -1, 1, 0, 0, 0, 7, 1};
    vecs[1] = '{0, 0,  1, 0, 1, 0, 0, 6, 1};
    vecs[2] = '{0, 0,  0, 0, 0, 1, 0, 6, 0};
    vecs[3] = '{1, 2,  1, 0, 1, 0, 0, 3, 1};
    vecs[4] = '{0, 2, -1, 1, 0, 0, 0, 2, 1};
    vecs[5] = '{0, 2,  1, 0, 1, 0, 0, 1, 1};
    vecs[6] = '{0, 2, -1, 1, 0, 0, 1, 0, 1};

    reset         = 1'b0;
    bus.enable    = 1'b0;
    bus.btn_pulse = 1'b0;
    bus.data_inp  = 4'd0;
    bus.gameLevel = 2'd0;
    bus.timeout   = 1'b0;
    m_lfsr        = SEED;
    clear_model();
    e_secret = 0;

    repeat (2) @(negedge clk);
    check_all("reset");
    check("reset dec", int'(bus.decrement), 0);
    reset = 1'b1;
    tick();
    check_all("idle");

    // table-driven games
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].new_game) begin
        end_game();
        start_game(vecs[i].level);
      end
      g = e_secret + vecs[i].delta;
      enter_digit(g / 10);
      enter_digit(g % 10);
      tick();
      check($sformatf("vec%0d less", i),     int'(bus.signalLess),    vecs[i].less);
      check($sformatf("vec%0d greater", i),  int'(bus.signalGreater), vecs[i].greater);
      check($sformatf("vec%0d won", i),      int'(bus.userWon),       vecs[i].won);
      check($sformatf("vec%0d lost", i),     int'(bus.userLost),      vecs[i].lost);
      check($sformatf("vec%0d attempts", i), int'(bus.attemptsLeft),  vecs[i].att);
      check($sformatf("vec%0d dec", i),      int'(bus.decrement),     vecs[i].dec);
      check($sformatf("vec%0d secret", i),   int'(bus.secretPrime),   e_secret);
      apply_guess(g);
      tick();
      e_dec = 0;
      check($sformatf("vec%0d dec_end", i), int'(bus.decrement), 0);
    end

    // level 3: three wrong guesses end the game; later digits do nothing
    end_game();
    start_game(3);
    run_guess(e_secret + 1, "l3 g1");
    run_guess(e_secret - 1, "l3 g2");
    run_guess(e_secret + 1, "l3 g3");
    enter_digit(1);
    enter_digit(2);
    tick();
    check_all("l3 after lost");
    check("l3 after lost dec", int'(bus.decrement), 0);

    // out-of-range digit is ignored in WAIT_TENS
    end_game();
    start_game(1);
    enter_digit(4'hC);
    check_all("bad digit");
    run_guess(2, "guess 02");

    // timeout together with the units digit
    end_game();
    start_game(0);
    run_guess(e_secret + 1, "pre timeout");
    enter_digit(5);
    bus.btn_pulse = 1'b1;
    bus.data_inp  = 4'd5;
    bus.timeout   = 1'b1;
    tick();
    bus.btn_pulse = 1'b0;
    bus.timeout   = 1'b0;
    e_lost = 1;
    check_all("timeout");
    check("timeout dec", int'(bus.decrement), 0);
    tick();
    check_all("timeout hold");
    check("timeout dec hold", int'(bus.decrement), 0);

    // asynchronous reset in WAIT_UNITS with enable held high
    end_game();
    start_game(0);
    enter_digit(1);
    #2;
    reset = 1'b0;
    #1;
    m_lfsr = SEED;
    clear_model();
    e_secret = 0;
    check_all("async reset");
    check("async reset dec", int'(bus.decrement), 0);
    @(negedge clk);
    check_all("reset held");
    reset = 1'b1;
    start_game(0);

    // random games against the model
    for (int game = 0; game < 30; game++) begin
      end_game();
      start_game(int'($urandom_range(0, 3)));
      while (!e_won && !e_lost) begin
        if ($urandom_range(0, 4) == 0) begin
          enter_digit(int'($urandom_range(10, 15)));
          check_all("rnd bad digit");
        end
        r = int'($urandom_range(0, 3));
        if (r == 0) g = e_secret;
        else if (r == 1) begin
          g = e_secret + int'($urandom_range(0, 6)) - 3;
          if (g < 0) g = 0;
          if (g > 99) g = 99;
        end else g = int'($urandom_range(0, 99));
        run_guess(g, $sformatf("rnd%0d g%0d", game, g));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
